// File: rtl/feature_pkg.sv
// Shared encodings for the feature RAM: access modes, clear-FSM states and an
// index-width helper used to size the storage array address.
package feature_pkg;

    typedef enum logic {
        MODE_ROW  = 1'b0,
        MODE_FEAT = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/feature_ram_bank.sv
// 1W1R storage array with per-feature write enables and a registered read port.
// Addresses arrive already range-checked, so only the bits needed for DEPTH are taken.
module feature_ram_bank #(
    parameter int  DEPTH      = 1024,
    parameter int  IDX_W      = 10,
    parameter int  LENGTH     = 16,
    parameter int  FEAT_WIDTH = 16,
    localparam int DATA_WIDTH = LENGTH * FEAT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LENGTH-1:0]     wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: the array itself has no reset; contents are zeroed by the clear sweep.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < LENGTH; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_idx][i*FEAT_WIDTH +: FEAT_WIDTH] <= wr_data[i*FEAT_WIDTH +: FEAT_WIDTH];
                end
            end
        end
    end

    // NOTE: non-blocking reads of r_mem see the pre-write row on a same-address collision.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_idx];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/feature_ram.sv
// Feature RAM top: clear FSM, access range checks, write-lane generation and
// read-side feature selection around the feature_ram_bank storage array.
module feature_ram
    import feature_pkg::*;
#(
    parameter int  ADDR_WIDTH = 10,
    parameter int  DEPTH      = 1024,
    parameter int  LENGTH     = 16,
    parameter int  LEN_BITS   = 4,
    parameter int  FEAT_WIDTH = 16,
    localparam int DATA_WIDTH = LENGTH * FEAT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_mode,
    input  logic [LEN_BITS-1:0]   wr_feat,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_mode,
    input  logic [LEN_BITS-1:0]   rd_feat,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  err
);

    localparam int                    IDX_W     = idx_bits(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [LEN_BITS:0]     LEN_LIM   = (LEN_BITS+1)'(LENGTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW  = ADDR_WIDTH'(DEPTH - 1);

    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic                  w_busy;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_busy = 1'b1;
                if (r_ptr == LAST_ROW) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Feature index is only range-checked for feature-mode accesses.
    logic w_wr_ok, w_rd_ok, w_wr_go, w_rd_go, w_bad;

    assign w_wr_ok = ({1'b0, wr_addr} < DEPTH_LIM) &&
                     ((wr_mode == MODE_ROW) || ({1'b0, wr_feat} < LEN_LIM));
    assign w_rd_ok = ({1'b0, rd_addr} < DEPTH_LIM) &&
                     ((rd_mode == MODE_ROW) || ({1'b0, rd_feat} < LEN_LIM));
    assign w_wr_go = wr_en && !w_busy && w_wr_ok;
    assign w_rd_go = rd_en && !w_busy && w_rd_ok;
    assign w_bad   = !w_busy && ((wr_en && !w_wr_ok) || (rd_en && !w_rd_ok));

    logic                  w_bank_we;
    logic [IDX_W-1:0]      w_bank_widx;
    logic [LENGTH-1:0]     w_bank_be;
    logic [DATA_WIDTH-1:0] w_bank_wdata;
    logic [DATA_WIDTH-1:0] w_bank_rdata;

    always_comb begin
        w_bank_we    = w_wr_go;
        w_bank_widx  = wr_addr[IDX_W-1:0];
        w_bank_wdata = (wr_mode == MODE_FEAT) ? {LENGTH{wr_data[FEAT_WIDTH-1:0]}} : wr_data;
        for (int i = 0; i < LENGTH; i++) begin
            w_bank_be[i] = (wr_mode == MODE_ROW) || (wr_feat == LEN_BITS'(i));
        end
        if (w_busy) begin
            w_bank_we    = 1'b1;
            w_bank_widx  = r_ptr[IDX_W-1:0];
            w_bank_be    = '1;
            w_bank_wdata = '0;
        end
    end

    feature_ram_bank #(
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .LENGTH     (LENGTH),
        .FEAT_WIDTH (FEAT_WIDTH)
    ) u_bank (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (w_bank_we),
        .wr_idx  (w_bank_widx),
        .wr_be   (w_bank_be),
        .wr_data (w_bank_wdata),
        .rd_en   (w_rd_go),
        .rd_idx  (rd_addr[IDX_W-1:0]),
        .rd_data (w_bank_rdata)
    );

    logic                r_rd_valid;
    logic                r_rd_mode;
    logic [LEN_BITS-1:0] r_rd_feat;
    logic                r_err;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rd_valid <= 1'b0;
            r_rd_mode  <= MODE_ROW;
            r_rd_feat  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_go;
            if (w_rd_go) begin
                r_rd_mode <= rd_mode;
                r_rd_feat <= rd_feat;
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Mode and feature are captured with the read, so rd_data holds while idle.
    logic [FEAT_WIDTH-1:0] w_rd_slice;

    always_comb begin
        w_rd_slice = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (r_rd_feat == LEN_BITS'(i)) begin
                w_rd_slice = w_bank_rdata[i*FEAT_WIDTH +: FEAT_WIDTH];
            end
        end
    end

    assign rd_data  = (r_rd_mode == MODE_FEAT) ? DATA_WIDTH'(w_rd_slice) : w_bank_rdata;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;
    assign busy     = w_busy;

endmodule

// File: tb/tb_feature_ram.sv
// Self-checking bench for feature_ram (DEPTH=4, LENGTH=4, FEAT_WIDTH=8): directed
// vector table, hand-written clear/reset sequences and randomized traffic vs a model.
module tb_feature_ram;

    localparam int AW = 3;
    localparam int DP = 4;
    localparam int LN = 4;
    localparam int LB = 3;
    localparam int FW = 8;
    localparam int DW = LN * FW;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          clr;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_mode;
    logic [LB-1:0] wr_feat;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_mode;
    logic [LB-1:0] rd_feat;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          err;

    always #5 CLK = ~CLK;

    feature_ram #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DP),
        .LENGTH     (LN),
        .LEN_BITS   (LB),
        .FEAT_WIDTH (FW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (clr),
        .busy     (busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mode  (wr_mode),
        .wr_feat  (wr_feat),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_mode  (rd_mode),
        .rd_feat  (rd_feat),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .err      (err)
    );

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic          wr_mode;
        logic [LB-1:0] wr_feat;
        logic [DW-1:0] wr_data;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          rd_mode;
        logic [LB-1:0] rd_feat;
    } acc_t;

    typedef struct {
        acc_t          a;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain array of rows, sticky error, last returned read value.
    logic [DW-1:0] model_mem [DP];
    logic          model_err;
    logic [DW-1:0] model_last;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic acc_t mk_acc(input logic we, input int wa, input logic wm, input int wf,
                                    input logic [DW-1:0] wd, input logic re, input int ra,
                                    input logic rm, input int rf);
        acc_t a;
        a.wr_en   = we;
        a.wr_addr = AW'(wa);
        a.wr_mode = wm;
        a.wr_feat = LB'(wf);
        a.wr_data = wd;
        a.rd_en   = re;
        a.rd_addr = AW'(ra);
        a.rd_mode = rm;
        a.rd_feat = LB'(rf);
        return a;
    endfunction

    function automatic vec_t mk_vec(input acc_t a, input logic ev, input logic [DW-1:0] ed);
        vec_t v;
        v.a         = a;
        v.exp_valid = ev;
        v.exp_data  = ed;
        return v;
    endfunction

    task automatic drive(input acc_t a);
        wr_en   = a.wr_en;
        wr_addr = a.wr_addr;
        wr_mode = a.wr_mode;
        wr_feat = a.wr_feat;
        wr_data = a.wr_data;
        rd_en   = a.rd_en;
        rd_addr = a.rd_addr;
        rd_mode = a.rd_mode;
        rd_feat = a.rd_feat;
    endtask

    task automatic drive_idle();
        drive(mk_acc(0, 0, 0, 0, '0, 0, 0, 0, 0));
        clr = 1'b0;
    endtask

    task automatic model_reset_mem();
        for (int r = 0; r < DP; r++) model_mem[r] = '0;
    endtask

    // Predict one idle-state access: read sees pre-write contents, then the write lands.
    task automatic model_step(input acc_t a, output logic ev, output logic [DW-1:0] ed);
        bit rd_ok, wr_ok;
        int ra, rf, wa, wf;
        ra = int'(a.rd_addr);
        rf = int'(a.rd_feat);
        wa = int'(a.wr_addr);
        wf = int'(a.wr_feat);
        rd_ok = (ra < DP) && (!a.rd_mode || rf < LN);
        wr_ok = (wa < DP) && (!a.wr_mode || wf < LN);
        ev = a.rd_en && rd_ok;
        if (ev) begin
            model_last = a.rd_mode ? ((model_mem[ra] >> (FW * rf)) & DW'(8'hFF)) : model_mem[ra];
        end
        ed = model_last;
        if (a.wr_en && wr_ok) begin
            if (a.wr_mode) model_mem[wa][FW*wf +: FW] = a.wr_data[FW-1:0];
            else           model_mem[wa] = a.wr_data;
        end
        if ((a.rd_en && !rd_ok) || (a.wr_en && !wr_ok)) model_err = 1'b1;
    endtask

    task automatic run(input string tag, input acc_t a, input logic ev, input logic [DW-1:0] ed);
        drive(a);
        tick();
        check({tag, " rd_valid"}, DW'(rd_valid), DW'(ev));
        check({tag, " rd_data"}, rd_data, ed);
        check({tag, " err"}, DW'(err), DW'(model_err));
        drive_idle();
    endtask

    task automatic model_run(input string tag, input acc_t a);
        logic          ev;
        logic [DW-1:0] ed;
        model_step(a, ev, ed);
        run(tag, a, ev, ed);
    endtask

    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    task automatic read_all_rows(input string tag);
        for (int r = 0; r < DP; r++) model_run(tag, mk_acc(0, 0, 0, 0, '0, 1, r, 0, 0));
    endtask

    vec_t tbl [9];

    initial begin
        int            cnt;
        logic          ev;
        logic [DW-1:0] ed;
        acc_t          a;

        tbl[0] = mk_vec(mk_acc(1, 2, 0, 0, 32'hAABBCCDD, 0, 0, 0, 0), 0, 32'h0);
        tbl[1] = mk_vec(mk_acc(1, 2, 1, 1, 32'h00000011, 0, 0, 0, 0), 0, 32'h0);
        tbl[2] = mk_vec(mk_acc(0, 0, 0, 0, '0,           1, 2, 0, 0), 1, 32'hAABB11DD);
        tbl[3] = mk_vec(mk_acc(0, 0, 0, 0, '0,           1, 2, 1, 3), 1, 32'h000000AA);
        tbl[4] = mk_vec(mk_acc(1, 1, 0, 0, 32'h12345678, 1, 1, 0, 0), 1, 32'h0);
        tbl[5] = mk_vec(mk_acc(0, 0, 0, 0, '0,           1, 1, 0, 0), 1, 32'h12345678);
        tbl[6] = mk_vec(mk_acc(1, 0, 1, 0, 32'hFFFFFF5A, 1, 2, 1, 0), 1, 32'h000000DD);
        tbl[7] = mk_vec(mk_acc(0, 0, 0, 0, '0,           1, 0, 0, 0), 1, 32'h0000005A);
        tbl[8] = mk_vec(mk_acc(0, 0, 0, 0, '0,           0, 0, 0, 0), 0, 32'h0000005A);

        RST_N = 1'b0;
        drive_idle();
        tick();
        check("reset busy", DW'(busy), 1);
        check("reset rd_valid", DW'(rd_valid), 0);
        check("reset rd_data", rd_data, 0);
        check("reset err", DW'(err), 0);

        RST_N = 1'b1;
        wait_sweep(cnt);
        check("initial sweep cycles", DW'(cnt), DP);
        check("initial sweep done", DW'(busy), 0);
        model_reset_mem();
        model_err  = 1'b0;
        model_last = '0;
        read_all_rows("cleared row");

        for (int i = 0; i < 9; i++) begin
            model_step(tbl[i].a, ev, ed);
            run($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp_valid, tbl[i].exp_data);
        end

        // Out-of-range accesses are dropped and raise the sticky error flag.
        model_run("bad wr addr", mk_acc(1, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
        check("err after bad addr", DW'(err), 1);
        model_run("bad feat wr", mk_acc(1, 3, 1, 4, 32'h000000EE, 0, 0, 0, 0));
        model_run("bad feat rd", mk_acc(0, 0, 0, 0, '0, 1, 0, 1, 5));
        model_run("bad rd addr", mk_acc(0, 0, 0, 0, '0, 1, 7, 0, 0));
        read_all_rows("rows after bad");

        for (int i = 0; i < 300; i++) begin
            a = mk_acc($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 1),
                       $urandom_range(0, 5), $urandom, $urandom_range(0, 1),
                       $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 5));
            model_run("random", a);
        end
        read_all_rows("rows after random");

        // Clear sweep: requests and a repeated clr during the sweep are ignored.
        clr = 1'b1;
        tick();
        check("clr busy", DW'(busy), 1);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            drive(mk_acc(1, cnt % DP, 0, 0, 32'hFFFFFFFF, 1, cnt % DP, 0, 0));
            clr = 1'b1;
            tick();
            check("busy rd_valid", DW'(rd_valid), 0);
            check("busy rd_data hold", rd_data, model_last);
            check("busy err", DW'(err), DW'(model_err));
        end
        drive_idle();
        check("clr sweep cycles", DW'(cnt), DP);
        model_reset_mem();
        read_all_rows("rows after clr");

        model_run("pre-reset wr3", mk_acc(1, 3, 0, 0, 32'hCAFEF00D, 0, 0, 0, 0));
        RST_N = 1'b0;
        tick();
        check("reset2 err", DW'(err), 0);
        check("reset2 rd_data", rd_data, 0);
        RST_N = 1'b1;
        tick();
        tick();
        check("mid-sweep busy", DW'(busy), 1);
        RST_N = 1'b0;
        tick();
        check("mid-sweep reset busy", DW'(busy), 1);
        RST_N = 1'b1;
        wait_sweep(cnt);
        check("restarted sweep cycles", DW'(cnt), DP);
        model_reset_mem();
        model_err  = 1'b0;
        model_last = '0;
        read_all_rows("rows after restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
